// File: rtl/yrv_aux_uart_rx.sv
// 16x-oversampled UART receiver: two-flop line sync, frame FSM and a first-word fall-through RX FIFO.
// An entry lands 1 clk after the stop-bit sample; there is no backpressure, so a frame arriving at a full FIFO is dropped and flags overrun.
module yrv_aux_uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 aux_uart_rx,
   input  logic [15:0]          baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic [CW-1:0]        irq_thresh,
   input  logic                 rd_req,
   input  logic                 err_clr,
   output logic [DATA_BITS+1:0] rd_data,
   output logic                 rx_valid,
   output logic [CW-1:0]        fifo_count,
   output logic                 overrun,
   output logic                 irq
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic                 parity_err;
      logic                 frame_err;
      logic [DATA_BITS-1:0] data;
   } rx_entry_t;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   logic                 rx_meta, rx_sync;
   logic [15:0]          pre_cnt, div_q;
   logic [3:0]           phase;
   logic                 tick, mid, start_det;
   state_t               state;
   logic [DATA_BITS-1:0] shift;
   logic [3:0]           bit_cnt;
   logic                 par_en_q, par_odd_q, par_err_q;
   logic                 push_vld;
   rx_entry_t            push_dat;

   rx_entry_t            mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 full, do_pop, do_push;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= aux_uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // div_q reloads only on a wrap (or start detection), so baud_div edits never split a tick period
   assign tick      = (pre_cnt == div_q);
   assign mid       = tick && (phase == 4'd7);
   assign start_det = (state == IDLE) && !rx_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         div_q   <= '0;
         phase   <= '0;
      end else if (start_det) begin
         pre_cnt <= '0;
         div_q   <= baud_div;
         phase   <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         div_q   <= baud_div;
         phase   <= phase + 4'd1;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state     <= START;
                  par_en_q  <= parity_en;
                  par_odd_q <= parity_odd;
                  par_err_q <= 1'b0;
               end
            end
            START: begin
               if (mid) begin
                  state   <= rx_sync ? IDLE : DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (mid) begin
                  shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(DATA_BITS - 1))
                     state <= par_en_q ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (mid) begin
                  par_err_q <= (^shift) ^ rx_sync ^ par_odd_q;
                  state     <= STOP;
               end
            end
            STOP: begin
               if (mid)
                  state <= rx_sync ? IDLE : BREAK;
            end
            BREAK: begin
               if (rx_sync)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign push_vld = (state == STOP) && mid;
   assign push_dat = {par_err_q, ~rx_sync, shift};

   // A push into a full FIFO is still accepted when the head is popped in the same cycle
   assign full    = (fifo_count == CW'(FIFO_DEPTH));
   assign do_pop  = rd_req && rx_valid;
   assign do_push = push_vld && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

   assign rd_data  = mem[rd_ptr];
   assign rx_valid = (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overrun    <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            fifo_count <= fifo_count + 1'b1;
         else if (!do_push && do_pop)
            fifo_count <= fifo_count - 1'b1;
         if (push_vld && !do_push)
            overrun <= 1'b1;
         else if (err_clr)
            overrun <= 1'b0;
         irq <= ((fifo_count >= irq_thresh) && (fifo_count != '0)) || overrun;
      end
   end

endmodule
